// File: rtl/vout_timing_pkg.sv
// Shared timing constants and types for the video-output reader.
package vout_timing_pkg;

  // Width of the raster counters and of the width/height outputs.
  localparam int CNT_W = 12;

  // RGB565 pixel: r[15:11], g[10:5], b[4:0].
  typedef logic [15:0] pixel_t;

  // 1280x720 timing.
  localparam int P720_H_ACTIVE  = 1280;
  localparam int P720_H_FP      = 110;
  localparam int P720_H_SYNC    = 40;
  localparam int P720_H_BP      = 220;
  localparam int P720_V_ACTIVE  = 720;
  localparam int P720_V_FP      = 5;
  localparam int P720_V_SYNC    = 5;
  localparam int P720_V_BP      = 20;

  // 1920x1080 timing.
  localparam int P1080_H_ACTIVE = 1920;
  localparam int P1080_H_FP     = 88;
  localparam int P1080_H_SYNC   = 44;
  localparam int P1080_H_BP     = 148;
  localparam int P1080_V_ACTIVE = 1080;
  localparam int P1080_V_FP     = 4;
  localparam int P1080_V_SYNC   = 5;
  localparam int P1080_V_BP     = 36;

  // 720x480 timing.
  localparam int P480_H_ACTIVE  = 720;
  localparam int P480_H_FP      = 16;
  localparam int P480_H_SYNC    = 62;
  localparam int P480_H_BP      = 60;
  localparam int P480_V_ACTIVE  = 480;
  localparam int P480_V_FP      = 9;
  localparam int P480_V_SYNC    = 6;
  localparam int P480_V_BP      = 30;

  // Line/frame totals and active windows for the default 720p mode.
  localparam int P720_H_TOTAL     = P720_H_SYNC + P720_H_BP + P720_H_ACTIVE + P720_H_FP;
  localparam int P720_V_TOTAL     = P720_V_SYNC + P720_V_BP + P720_V_ACTIVE + P720_V_FP;
  localparam int P720_H_ACT_START = P720_H_SYNC + P720_H_BP;
  localparam int P720_H_ACT_END   = P720_H_ACT_START + P720_H_ACTIVE;
  localparam int P720_V_ACT_START = P720_V_SYNC + P720_V_BP;
  localparam int P720_V_ACT_END   = P720_V_ACT_START + P720_V_ACTIVE;

  // True when cnt lies in [start, start+len).
  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input int start, input int len);
    return (cnt >= CNT_W'(start)) && (cnt < CNT_W'(start + len));
  endfunction

endpackage

// File: rtl/vout_sync_counter.sv
// Raster position counters and the raw sync / active-window decode.
module vout_sync_counter
  import vout_timing_pkg::*;
#(
  parameter int H_ACTIVE = P720_H_ACTIVE,
  parameter int H_FP     = P720_H_FP,
  parameter int H_SYNC   = P720_H_SYNC,
  parameter int H_BP     = P720_H_BP,
  parameter int V_ACTIVE = P720_V_ACTIVE,
  parameter int V_FP     = P720_V_FP,
  parameter int V_SYNC   = P720_V_SYNC,
  parameter int V_BP     = P720_V_BP
) (
  input  logic vout_clk,
  input  logic rst,
  output logic frame_start,
  output logic hs_raw,
  output logic vs_raw,
  output logic h_act,
  output logic v_act
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  // Pixel counter wraps each line; line counter advances on that wrap.
  always_ff @(posedge vout_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Decode sync pulses and active windows straight from the counters.
  always_comb begin
    // NOTE: every output gets a value on every path, so no latch is inferred.
    frame_start = (h_cnt == '0) && (v_cnt == '0);
    hs_raw      = h_cnt < CNT_W'(H_SYNC);
    vs_raw      = v_cnt < CNT_W'(V_SYNC);
    h_act       = in_window(h_cnt, H_SYNC + H_BP, H_ACTIVE);
    v_act       = in_window(v_cnt, V_SYNC + V_BP, V_ACTIVE);
  end

endmodule

// File: rtl/vout_timing_reader.sv
// Video-output timing generator and pixel fetch from the frame buffer FIFO.
module vout_timing_reader
  import vout_timing_pkg::*;
#(
  parameter int H_ACTIVE = P720_H_ACTIVE,
  parameter int H_FP     = P720_H_FP,
  parameter int H_SYNC   = P720_H_SYNC,
  parameter int H_BP     = P720_H_BP,
  parameter int V_ACTIVE = P720_V_ACTIVE,
  parameter int V_FP     = P720_V_FP,
  parameter int V_SYNC   = P720_V_SYNC,
  parameter int V_BP     = P720_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        vout_clk,
  input  logic        rst,
  input  logic        output_en,
  output logic        vout_vs,
  output logic        vout_rd_req,
  input  logic [15:0] vout_data,
  input  logic        fifo_rdempty,
  output logic [11:0] vout_width,
  output logic [11:0] vout_height,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output logic [15:0] video_data,
  output logic        underflow,
  output logic [15:0] underflow_cnt
);

  localparam logic HS_IDLE = ~HS_POL;
  localparam logic VS_IDLE = ~VS_POL;

  logic   frame_start, hs_raw, vs_raw, h_act, v_act;
  logic   frame_en, want;
  logic   act_q1, hs_q1, starve_q1;
  logic   data_sel;
  pixel_t out_pix;

  assign vout_width  = 12'(H_ACTIVE);
  assign vout_height = 12'(V_ACTIVE);

  vout_sync_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_sync (
    .vout_clk    (vout_clk),
    .rst         (rst),
    .frame_start (frame_start),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .h_act       (h_act),
    .v_act       (v_act)
  );

  // Enable is latched once per frame so a frame is never half-fetched.
  always_ff @(posedge vout_clk) begin
    if (rst)              frame_en <= 1'b0;
    else if (frame_start) frame_en <= output_en;
  end

  assign want = h_act & v_act & frame_en;

  // Stage 1: read request, frame-buffer vsync and delayed decode.
  always_ff @(posedge vout_clk) begin
    if (rst) begin
      vout_rd_req <= 1'b0;
      vout_vs     <= 1'b0;
      act_q1      <= 1'b0;
      hs_q1       <= 1'b0;
      starve_q1   <= 1'b0;
    end else begin
      vout_rd_req <= want & ~fifo_rdempty;
      vout_vs     <= vs_raw;
      act_q1      <= h_act & v_act;
      hs_q1       <= hs_raw;
      starve_q1   <= want & fifo_rdempty;
    end
  end

  // Stage 2: video port timing, aligned with the FIFO's returned pixel.
  always_ff @(posedge vout_clk) begin
    if (rst) begin
      video_de <= 1'b0;
      video_hs <= HS_IDLE;
      video_vs <= VS_IDLE;
      data_sel <= 1'b0;
    end else begin
      video_de <= act_q1;
      video_hs <= hs_q1 ^ HS_IDLE;
      video_vs <= vout_vs ^ VS_IDLE;
      data_sel <= vout_rd_req;
    end
  end

  // FIFO q is valid exactly in the stage-2 cycle; black when nothing was read.
  always_comb begin
    out_pix = '0;
    if (data_sel) out_pix = vout_data;
  end

  assign video_data = out_pix;

  // Starve tracking, cleared on the edge where vout_vs rises.
  always_ff @(posedge vout_clk) begin
    if (rst) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (vs_raw && !vout_vs) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (starve_q1) begin
      underflow <= 1'b1;
      if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

endmodule
